// File: rtl/load_store_unit.sv
// Load/store unit: turns a held lsu_en_i request into one request/grant/rvalid
// bus transaction, with lane steering, load extension and a stall watchdog.
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lsu_en_i,
    input  logic                  lsu_we_i,
    input  logic [1:0]            lsu_size_i,
    input  logic                  lsu_sign_ext_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [31:0]           lsu_wdata_i,
    output logic                  lsu_done_o,
    output logic                  lsu_err_o,
    output logic [31:0]           lsu_rdata_o,
    output logic                  data_req_o,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i,
    input  logic                  data_err_i
);

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        WAIT_GNT    = 2'b01,
        WAIT_RVALID = 2'b10
    } state_e;

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] off,
                                                input logic [1:0] size, input logic sx);
        logic [31:0] shifted;
        shifted = raw >> {off, 3'b000};
        case (size)
            2'b00:   return {{24{sx & shifted[7]}}, shifted[7:0]};
            2'b01:   return {{16{sx & shifted[15]}}, shifted[15:0]};
            default: return shifted;
        endcase
    endfunction

    function automatic logic [31:0] replicate_store(input logic [31:0] wd, input logic [1:0] size);
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    state_e        state_q, state_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          sx_q, sx_d;
    logic          we_q, we_d;
    logic          abort_q, abort_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;

    logic          active_s, misaligned_s, wd_hit_s, req_s, done_s, err_s;
    logic [3:0]    be_s;

    // Request decode: alignment check and byte-lane enables
    always_comb begin
        be_s         = 4'b0000;
        misaligned_s = 1'b0;
        case (lsu_size_i)
            2'b00: be_s = 4'b0001 << lsu_addr_i[1:0];
            2'b01: begin
                be_s         = 4'b0011 << {lsu_addr_i[1], 1'b0};
                misaligned_s = lsu_addr_i[0];
            end
            2'b10: begin
                be_s         = 4'b1111;
                misaligned_s = |lsu_addr_i[1:0];
            end
            default: misaligned_s = 1'b1;
        endcase
    end

    // Next-state, watchdog and combinational handshake outputs
    always_comb begin
        state_d  = state_q;
        off_d    = off_q;
        size_d   = size_q;
        sx_d     = sx_q;
        we_d     = we_q;
        abort_d  = abort_q;
        wd_cnt_d = wd_cnt_q;
        req_s    = 1'b0;
        done_s   = 1'b0;
        err_s    = 1'b0;
        active_s = lsu_en_i & rst_n;
        if (TIMEOUT_CYCLES != 0) begin
            wd_hit_s = (wd_cnt_q == WD_LAST);
        end else begin
            wd_hit_s = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (active_s && misaligned_s) begin
                    err_s = 1'b1;
                end else if (active_s) begin
                    req_s    = 1'b1;
                    off_d    = lsu_addr_i[1:0];
                    size_d   = lsu_size_i;
                    sx_d     = lsu_sign_ext_i;
                    we_d     = lsu_we_i;
                    abort_d  = 1'b0;
                    wd_cnt_d = '0;
                    state_d  = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_GNT: begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                if (!active_s) begin
                    state_d = IDLE;
                end else if (data_gnt_i) begin
                    req_s   = 1'b1;
                    state_d = WAIT_RVALID;
                end else if (wd_hit_s) begin
                    req_s   = 1'b1;
                    done_s  = 1'b1;
                    err_s   = 1'b1;
                    state_d = IDLE;
                end else begin
                    req_s = 1'b1;
                end
            end
            WAIT_RVALID: begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                // Once the controller lets go, the response is drained without a done
                abort_d  = abort_q | ~active_s;
                if (data_rvalid_i) begin
                    state_d = IDLE;
                    done_s  = ~abort_d;
                    err_s   = ~abort_d & data_err_i;
                end else if (wd_hit_s) begin
                    state_d = IDLE;
                    done_s  = ~abort_d;
                    err_s   = ~abort_d;
                end else begin
                    state_d = WAIT_RVALID;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched request fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            off_q    <= 2'b00;
            size_q   <= 2'b00;
            sx_q     <= 1'b0;
            we_q     <= 1'b0;
            abort_q  <= 1'b0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            off_q    <= off_d;
            size_q   <= size_d;
            sx_q     <= sx_d;
            we_q     <= we_d;
            abort_q  <= abort_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign lsu_done_o   = done_s;
    assign lsu_err_o    = err_s;
    assign lsu_rdata_o  = (done_s && !we_q) ? extend_load(data_rdata_i, off_q, size_q, sx_q) : 32'h0000_0000;
    assign data_req_o   = req_s;
    assign data_addr_o  = req_s ? {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign data_we_o    = req_s & lsu_we_i;
    assign data_be_o    = req_s ? be_s : 4'b0000;
    assign data_wdata_o = req_s ? replicate_store(lsu_wdata_i, lsu_size_i) : 32'h0000_0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short watchdog (TIMEOUT_CYCLES=4).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_en_i, lsu_we_i, lsu_sign_ext_i;
    logic [1:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_done_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;
    logic        data_req_o, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;
    logic        data_gnt_i, data_rvalid_i, data_err_i;
    logic [31:0] data_rdata_i;

    int n_checks = 0;
    int n_fails  = 0;
    int req_cycles;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_en_i(lsu_en_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
        .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_done_o(lsu_done_o), .lsu_err_o(lsu_err_o), .lsu_rdata_o(lsu_rdata_o),
        .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        lsu_en_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00; lsu_sign_ext_i = 1'b0;
        lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0; data_err_i = 1'b0;
    endtask

    task automatic request(input logic we, input logic [1:0] size, input logic sx,
                           input logic [31:0] addr, input logic [31:0] wd, input logic gnt);
        lsu_en_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_sign_ext_i = sx;
        lsu_addr_i = addr; lsu_wdata_i = wd; data_gnt_i = gnt;
    endtask

    task automatic respond(input logic [31:0] rd, input logic err);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = rd; data_err_i = err;
    endtask

    initial begin
        quiet();
        rst_n = 1'b0;
        #2;
        check("rst_req", {31'b0, data_req_o}, 32'd0);
        check("rst_done_err", {30'b0, lsu_done_o, lsu_err_o}, 32'd0);
        check("rst_addr", data_addr_o, 32'h0);
        check("rst_be", {28'b0, data_be_o}, 32'h0);
        check("rst_rdata", lsu_rdata_o, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // LW 0x100, immediate grant, rvalid next cycle
        request(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1); #1;
        check("lw_req", {31'b0, data_req_o}, 32'd1);
        check("lw_be", {28'b0, data_be_o}, 32'hF);
        check("lw_addr", data_addr_o, 32'h100);
        check("lw_done_early", {31'b0, lsu_done_o}, 32'd0);
        tick();
        respond(32'hDEAD_BEEF, 1'b0); #1;
        check("lw_req_off", {31'b0, data_req_o}, 32'd0);
        check("lw_done", {30'b0, lsu_done_o, lsu_err_o}, 32'd2);
        check("lw_rdata", lsu_rdata_o, 32'hDEAD_BEEF);
        tick(); quiet(); #1;
        check("lw_done_pulse", {31'b0, lsu_done_o}, 32'd0);

        // LB / LBU at 0x103
        request(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b1); #1;
        check("lb_be", {28'b0, data_be_o}, 32'h8);
        tick(); respond(32'h80FF_FF12, 1'b0); #1;
        check("lb_rdata", lsu_rdata_o, 32'hFFFF_FF80);
        tick(); quiet();
        request(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b1);
        tick(); respond(32'h80FF_FF12, 1'b0); #1;
        check("lbu_rdata", lsu_rdata_o, 32'h0000_0080);
        tick(); quiet();

        // SH 0x202 with grant delayed three cycles; stray rvalid in WAIT_GNT
        req_cycles = 0;
        request(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_ABCD, 1'b0); #1;
        check("sh_be", {28'b0, data_be_o}, 32'hC);
        check("sh_wdata", data_wdata_o, 32'hABCD_ABCD);
        check("sh_addr", data_addr_o, 32'h200);
        check("sh_we", {31'b0, data_we_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            data_gnt_i = (i == 3) ? 1'b1 : 1'b0;
            data_rvalid_i = (i == 1) ? 1'b1 : 1'b0;
            #1;
            if (data_req_o) req_cycles++;
            if (i == 1) check("sh_stray_rvalid", {31'b0, lsu_done_o}, 32'd0);
            tick();
        end
        check("sh_req_cycles", req_cycles, 32'd4);
        respond(32'h0, 1'b0); #1;
        check("sh_done", {30'b0, lsu_done_o, lsu_err_o}, 32'd2);
        tick(); quiet();

        // Misaligned LW and illegal size: zero-latency error, no bus request
        request(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1'b1); #1;
        check("mis_err", {30'b0, lsu_done_o, lsu_err_o}, 32'd1);
        check("mis_req", {31'b0, data_req_o}, 32'd0);
        tick();
        request(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b1); #1;
        check("ill_err", {31'b0, lsu_err_o}, 32'd1);
        check("ill_req", {31'b0, data_req_o}, 32'd0);
        tick(); quiet();
        request(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0); #1;
        check("mis_still_idle", {31'b0, data_req_o}, 32'd1);
        tick(); quiet(); #1;
        check("abort_gnt", {31'b0, data_req_o}, 32'd0);
        tick();

        // Bus error on rvalid
        request(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b1);
        tick(); respond(32'h0, 1'b1); #1;
        check("bus_err", {30'b0, lsu_done_o, lsu_err_o}, 32'd3);
        tick(); quiet(); #1;
        check("bus_err_pulse", {30'b0, lsu_done_o, lsu_err_o}, 32'd0);

        // Watchdog: no grant for four wait cycles, then a late rvalid
        request(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("wd_wait", {31'b0, lsu_done_o}, 32'd0);
        end
        tick(); #1;
        check("wd_timeout", {30'b0, lsu_done_o, lsu_err_o}, 32'd3);
        tick(); quiet(); data_rvalid_i = 1'b1; #1;
        check("wd_late_rvalid", {30'b0, lsu_done_o, lsu_err_o}, 32'd0);
        tick(); quiet();
        request(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        tick(); respond(32'h1122_3344, 1'b0); #1;
        check("wd_recover", lsu_rdata_o, 32'h1122_3344);
        tick(); quiet();

        // Reset while in WAIT_RVALID
        request(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1);
        tick();
        respond(32'hFFFF_FFFF, 1'b0); rst_n = 1'b0; #1;
        check("rstmid_req", {31'b0, data_req_o}, 32'd0);
        check("rstmid_done", {30'b0, lsu_done_o, lsu_err_o}, 32'd0);
        check("rstmid_rdata", lsu_rdata_o, 32'h0);
        check("rstmid_be", {28'b0, data_be_o}, 32'h0);
        tick();
        quiet(); rst_n = 1'b1;
        request(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b1); #1;
        check("post_rst_req", {31'b0, data_req_o}, 32'd1);
        check("post_rst_be", {28'b0, data_be_o}, 32'hC);
        tick(); respond(32'h8001_0000, 1'b0); #1;
        check("post_rst_lh", lsu_rdata_o, 32'hFFFF_8001);
        tick(); quiet(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "bench time limit expired");
    end

endmodule
